// File: rtl/present_pkg.sv
// Shared widths, data types and FSM state encoding for the PRESENT encryptor controller.
package present_pkg;

    localparam int unsigned KEY_W      = 80;
    localparam int unsigned BLK_W      = 64;
    localparam int unsigned ROUNDS_DEF = 31;
    localparam int unsigned RND_W      = 5;
    localparam int unsigned CNT_W      = 32;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [BLK_W-1:0] blk_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_CAPT = 3'd4,
        ST_OUT  = 3'd5
    } state_e;

endpackage

// File: rtl/present_encryptor_ctrl.sv
// Sequences an external PRESENT-80 core: key reload, block load, ROUNDS iterations, capture, output.
// Optional completed-block counter enabled by defining PRESENT_CTRL_BLK_CNT_EN.
module present_encryptor_ctrl
    import present_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              key_we_i,
    input  logic [BLK_W-1:0]  pt_i,
    input  logic              pt_valid_i,
    output logic              pt_ready_o,
    output logic [BLK_W-1:0]  ct_o,
    output logic              ct_valid_o,
    input  logic              ct_ready_i,
    output logic              busy_o,
    output logic [KEY_W-1:0]  core_data_i,
    output logic              core_key_load,
    output logic              core_data_load,
    input  logic [BLK_W-1:0]  core_data_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);

    state_e           state_q, state_d;
    logic             key_ok_q, key_ok_d;
    key_t             key_reg_q, key_reg_d;
    blk_t             pt_reg_q, pt_reg_d;
    blk_t             ct_reg_q, ct_reg_d;
    logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;
    logic             pt_ready_q, pt_ready_d;
    logic             ct_valid_q, ct_valid_d;
    logic             busy_q, busy_d;
    logic             key_load_q, key_load_d;
    logic             data_load_q, data_load_d;
    key_t             core_bus_q, core_bus_d;
    logic             pt_hs;
    logic             ct_hs;

    assign pt_hs = pt_valid_i & pt_ready_q;
    assign ct_hs = ct_valid_q & ct_ready_i;

    // Next-state and registered-output logic; outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        key_ok_d  = key_ok_q;
        key_reg_d = key_reg_q;
        pt_reg_d  = pt_reg_q;
        ct_reg_d  = ct_reg_q;
        rnd_cnt_d = rnd_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (key_we_i) begin
                    key_reg_d = key_i;
                    key_ok_d  = 1'b1;
                end
                if (pt_hs) begin
                    pt_reg_d = pt_i;
                    state_d  = ST_KEY;
                end
            end
            ST_KEY:  state_d = ST_LOAD;
            ST_LOAD: begin
                rnd_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                rnd_cnt_d = RND_W'(rnd_cnt_q + RND_W'(1));
                if (rnd_cnt_q == RND_W'(ROUNDS - 1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                ct_reg_d = core_data_o;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (ct_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pt_ready_d  = (state_d == ST_IDLE) & key_ok_d;
        busy_d      = (state_d != ST_IDLE);
        // Valid rises one cycle into OUT and drops on the handshake edge.
        ct_valid_d  = (state_q == ST_OUT) & (state_d == ST_OUT);
        key_load_d  = (state_d == ST_KEY);
        data_load_d = (state_d == ST_LOAD);
        core_bus_d  = '0;
        if (state_d == ST_KEY) begin
            core_bus_d = key_reg_d;
        end else if (state_d == ST_LOAD) begin
            core_bus_d = KEY_W'(pt_reg_d);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            key_ok_q    <= 1'b0;
            key_reg_q   <= '0;
            pt_reg_q    <= '0;
            ct_reg_q    <= '0;
            rnd_cnt_q   <= '0;
            pt_ready_q  <= 1'b0;
            ct_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            key_load_q  <= 1'b0;
            data_load_q <= 1'b0;
            core_bus_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_ok_q    <= key_ok_d;
            key_reg_q   <= key_reg_d;
            pt_reg_q    <= pt_reg_d;
            ct_reg_q    <= ct_reg_d;
            rnd_cnt_q   <= rnd_cnt_d;
            pt_ready_q  <= pt_ready_d;
            ct_valid_q  <= ct_valid_d;
            busy_q      <= busy_d;
            key_load_q  <= key_load_d;
            data_load_q <= data_load_d;
            core_bus_q  <= core_bus_d;
        end
    end

`ifdef PRESENT_CTRL_BLK_CNT_EN
    logic [CNT_W-1:0] blk_cnt_q;

    // Counts completed output handshakes, wrapping naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_cnt_q <= '0;
        end else if ((state_q == ST_OUT) && ct_hs) begin
            blk_cnt_q <= CNT_W'(blk_cnt_q + CNT_W'(1));
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`else
    assign blk_cnt_o = '0;
`endif

    assign pt_ready_o     = pt_ready_q;
    assign ct_o           = ct_reg_q;
    assign ct_valid_o     = ct_valid_q;
    assign busy_o         = busy_q;
    assign core_data_i    = core_bus_q;
    assign core_key_load  = key_load_q;
    assign core_data_load = data_load_q;

endmodule

// File: tb/tb_present_encryptor_ctrl.sv
// Bench for present_encryptor_ctrl with a behavioural PRESENT-80 core and algorithmic reference.
module tb_present_encryptor_ctrl;

    localparam int ROUNDS = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key;
    logic        key_we;
    logic [63:0] pt;
    logic        pt_valid;
    logic        pt_ready;
    logic [63:0] ct;
    logic        ct_valid;
    logic        ct_ready;
    logic        busy;
    logic [79:0] core_din;
    logic        core_kl;
    logic        core_dl;
    logic [63:0] core_dout;
    logic [31:0] blk_cnt;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [79:0] cur_key = '0;
    int          blocks = 0;

    always #5 clk = ~clk;

    present_encryptor_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk_i(clk), .rst_i(rst), .key_i(key), .key_we_i(key_we),
        .pt_i(pt), .pt_valid_i(pt_valid), .pt_ready_o(pt_ready),
        .ct_o(ct), .ct_valid_o(ct_valid), .ct_ready_i(ct_ready), .busy_o(busy),
        .core_data_i(core_din), .core_key_load(core_kl), .core_data_load(core_dl),
        .core_data_o(core_dout), .blk_cnt_o(blk_cnt)
    );

    function automatic logic [3:0] sb4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] rk);
        logic [63:0] x, r;
        x = s ^ rk;
        for (int n = 0; n < 16; n++) x[n*4 +: 4] = sb4(x[n*4 +: 4]);
        r = '0;
        for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
        r[63] = x[63];
        return r;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] n;
        n = {k[18:0], k[79:19]};
        n[79:76] = sb4(n[79:76]);
        n[19:15] = n[19:15] ^ rc;
        return n;
    endfunction

    // Whole-block reference: 31 rounds plus final whitening.
    function automatic logic [63:0] present_ref(input logic [79:0] k0, input logic [63:0] p);
        logic [63:0] s;
        logic [79:0] k;
        s = p;
        k = k0;
        for (int i = 1; i <= 31; i++) begin
            s = round_fn(s, k[79:16]);
            k = key_upd(k, 5'(i));
        end
        return s ^ k[79:16];
    endfunction

    // Cycle-level core: one round per cycle when neither load strobe is high.
    logic [63:0] c_st  = '0;
    logic [79:0] c_key = '0;
    logic [4:0]  c_rc  = 5'd1;
    always_ff @(posedge clk) begin
        if (core_kl) begin
            c_key <= core_din;
            c_rc  <= 5'd1;
        end else if (core_dl) begin
            c_st <= core_din[63:0];
        end else begin
            c_st  <= round_fn(c_st, c_key[79:16]);
            c_key <= key_upd(c_key, c_rc);
            c_rc  <= c_rc + 5'd1;
        end
    end
    assign core_dout = c_st ^ c_key[79:16];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int b);
`ifdef PRESENT_CTRL_BLK_CNT_EN
        return 32'(b);
`else
        return 32'(b - b);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && (core_kl || core_dl)) chk("strobe_excl", 80'(core_kl & core_dl), 80'(0));
    end

    task automatic run_block(input logic [79:0] k, input bit wr, input bit same,
                             input logic [63:0] p, input int hold, input logic [63:0] exp,
                             input string nm);
        int w, lat;
        bit bad;
        logic [95:0] r96;
        if (wr && !same) begin
            key = k; key_we = 1'b1; step(); key_we = 1'b0;
        end
        w = 0;
        while (!pt_ready && w < 50) begin step(); w++; end
        chk({nm, " pt_ready"}, 80'(pt_ready), 80'(1));
        if (wr) cur_key = k;
        if (wr && same) begin key = k; key_we = 1'b1; end
        pt = p; pt_valid = 1'b1;
        step();
        pt_valid = 1'b0; key_we = 1'b0;
        chk({nm, " key_phase"}, {core_kl, core_dl, core_din}, {2'b10, cur_key});
        step();
        chk({nm, " load_phase"}, {core_kl, core_dl, core_din}, {2'b01, 16'h0, p});
        lat = 1; bad = 1'b0;
        while (!ct_valid && lat < 100) begin
            step(); lat++;
            if (core_din != '0 || core_kl || core_dl || !busy || pt_ready) bad = 1'b1;
        end
        chk({nm, " run_quiet"}, 80'(bad), 80'(0));
        chk({nm, " latency"}, 80'(lat), 80'(ROUNDS + 4));
        chk({nm, " ct"}, 80'(ct), 80'(exp));
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            key = r96[79:0]; key_we = 1'b1;
            step();
            if (!ct_valid || ct != exp || pt_ready || !busy) bad = 1'b1;
        end
        key_we = 1'b0;
        if (hold > 0) chk({nm, " out_hold"}, 80'(bad), 80'(0));
        ct_ready = 1'b1;
        step();
        ct_ready = 1'b0;
        blocks++;
        chk({nm, " after_hs"}, {78'(0), ct_valid, pt_ready}, 80'(2'b01));
        chk({nm, " blk_cnt"}, 80'(blk_cnt), 80'(cnt_exp(blocks)));
    endtask

    typedef struct {
        logic [79:0] key;
        bit          wr;
        bit          same;
        logic [63:0] pt;
        int          hold;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[4];
    logic [95:0] r96;
    logic [79:0] rk;
    logic [63:0] rp;
    bit          rwr;
    bit          bad;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{80'h0, 1'b1, 1'b0, 64'h0, 0, 64'h5579C1387B228445};
        vecs[1] = '{80'hFFFFFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 64'h0, 10, 64'hE72C46C0F5945049};
        vecs[2] = '{80'h0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2, 64'h3333DCD3213210D2};
        vecs[3] = '{80'h0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0, 64'hA112FFC72F68417B};

        rst = 1'b1; key = '0; key_we = 1'b0; pt = '0; pt_valid = 1'b0; ct_ready = 1'b0;
        step(); step();
        chk("reset_outs", {75'(0), pt_ready, ct_valid, busy, core_kl, core_dl}, 80'(0));
        chk("reset_bus", core_din, 80'(0));
        chk("reset_ct_cnt", {16'(0), ct}, {48'(0), blk_cnt});
        rst = 1'b0;
        step(); step();
        chk("no_key_no_ready", 80'(pt_ready), 80'(0));

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].key, vecs[i].wr, vecs[i].same, vecs[i].pt, vecs[i].hold,
                      vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            rk  = r96[79:0];
            rp  = {$urandom(), $urandom()};
            rwr = (i == 0) || ($urandom_range(0, 1) == 1);
            run_block(rk, rwr, ($urandom_range(0, 1) == 1), rp, $urandom_range(0, 4),
                      present_ref(rwr ? rk : cur_key, rp), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of RUN: block is abandoned and a fresh key is required.
        r96 = {$urandom(), $urandom(), $urandom()};
        key = r96[79:0]; key_we = 1'b1; step(); key_we = 1'b0;
        pt = {$urandom(), $urandom()}; pt_valid = 1'b1; step(); pt_valid = 1'b0;
        repeat (17) step();
        rst = 1'b1;
        #1;
        chk("midrun_rst_outs", {75'(0), pt_ready, ct_valid, busy, core_kl, core_dl}, 80'(0));
        chk("midrun_rst_bus", core_din, 80'(0));
        chk("midrun_rst_ct_cnt", {16'(0), ct}, {48'(0), blk_cnt});
        step(); step();
        rst = 1'b0;
        blocks = 0;
        bad = 1'b0;
        pt_valid = 1'b1;
        repeat (60) begin
            step();
            if (ct_valid || pt_ready || busy) bad = 1'b1;
        end
        pt_valid = 1'b0;
        chk("post_rst_idle", 80'(bad), 80'(0));

        rp = {$urandom(), $urandom()};
        r96 = {$urandom(), $urandom(), $urandom()};
        run_block(r96[79:0], 1'b1, 1'b0, rp, 1, present_ref(r96[79:0], rp), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/present_encryptor_ctrl.md
PRESENT_ENCRYPTOR_CTRL -- requirements
Module: present_encryptor_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 31, meaning the number of core iteration cycles between plaintext load and ciphertext capture.
REQ-002 SHALL have port clk_i  input  1  clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_i  input  80  cipher key.
REQ-005 SHALL have port key_we_i  input  1  key write strobe.
REQ-006 SHALL have port pt_i  input  64  plaintext.
REQ-007 SHALL have port pt_valid_i  input  1  plaintext valid.
REQ-008 SHALL have port pt_ready_o  output  1  plaintext accepted when high together with pt_valid_i.
REQ-009 SHALL have port ct_o  output  64  ciphertext.
REQ-010 SHALL have port ct_valid_o  output  1  ciphertext valid.
REQ-011 SHALL have port ct_ready_i  input  1  downstream accepts ciphertext.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port core_data_i  output  80  data bus to the encryption core.
REQ-014 SHALL have port core_key_load  output  1  core key-load strobe.
REQ-015 SHALL have port core_data_load  output  1  core state-load strobe.
REQ-016 SHALL have port core_data_o  input  64  core output, holding state XOR round key.
REQ-017 SHALL have port blk_cnt_o  output  32  count of completed blocks (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, KEY, LOAD, RUN, CAPT and OUT.
REQ-019 SHALL, in IDLE when key_we_i=1, write key_i into key_reg and set key_ok.
REQ-020 SHALL ignore key_we_i in every state other than IDLE.
REQ-021 SHALL drive pt_ready_o = (state==IDLE) & key_ok.
REQ-022 SHALL, on a pt handshake, latch pt_i into pt_reg and go to KEY.
REQ-023 SHALL, when key_we_i and a pt handshake occur in the same cycle, encrypt that block with the newly written key.
REQ-024 SHALL, in KEY, drive core_key_load=1 and core_data_i=key_reg for one cycle, then go to LOAD.
REQ-025 SHALL, in LOAD, drive core_data_load=1 and core_data_i={16'h0,pt_reg} for one cycle, clear rnd_cnt, then go to RUN.
REQ-026 SHALL reload the key in KEY for every block, because the core overwrites its key register while running.
REQ-027 SHALL, in RUN, hold both core strobes low and increment rnd_cnt (5 bits) each cycle.
REQ-028 SHALL go from RUN to CAPT after exactly ROUNDS cycles in RUN (rnd_cnt==ROUNDS-1).
REQ-029 SHALL, in CAPT, register core_data_o into ct_reg, then go to OUT.
REQ-030 SHALL, in OUT, drive ct_valid_o=1 and ct_o=ct_reg, hold both stable until ct_ready_i=1, then go to IDLE.
REQ-031 SHALL assert ct_valid_o exactly ROUNDS+4 cycles after the pt handshake edge (35 cycles for the default ROUNDS).
REQ-032 SHALL hold core_data_i at 0 in IDLE, RUN, CAPT and OUT.
REQ-033 SHALL never assert core_key_load and core_data_load in the same cycle.
REQ-034 SHALL allow pt_ready_o high at the earliest in the cycle after the OUT handshake (one-cycle bubble).

Reset
REQ-035 SHALL, while rst_i=1, force state=IDLE and clear key_ok, pt_ready_o, ct_valid_o, busy_o, core strobes, rnd_cnt, key_reg, pt_reg, ct_reg and blk_cnt_o.
REQ-036 SHALL, on reset during any state (including mid-RUN), abandon the block without producing ct_valid_o and require a new key write before any new pt is accepted.

Configuration
REQ-037 SHALL, when PRESENT_CTRL_BLK_CNT_EN is defined, increment blk_cnt_o on each OUT handshake and wrap 0xFFFFFFFF to 0.
REQ-038 SHALL, when PRESENT_CTRL_BLK_CNT_EN is undefined, tie blk_cnt_o to 0 and implement no counter flops.

Structure
REQ-039 SHALL place the FSM state enum, the KEY_W=80, BLK_W=64 and ROUNDS_DEF=31 constants, and the key/block typedefs in package present_pkg.
REQ-040 SHALL NOT contain any sub-module; the core is connected externally.

Verification
REQ-041 SHALL be verified with: key 0, pt 0 -> ct_o=5579C1387B228445 with ct_valid_o rising 35 cycles after the handshake.
REQ-042 SHALL be verified with: key FFFFFFFFFFFFFFFFFFFF, pt 0 -> E72C46C0F5945049; then pt FFFFFFFFFFFFFFFF with the same key, no key rewrite -> 3333DCD3213210D2.
REQ-043 SHALL be verified with: key_we_i and pt_valid_i in the same IDLE cycle (key 0, pt FFFFFFFFFFFFFFFF) -> A112FFC72F68417B.
REQ-044 SHALL be verified with: ct_ready_i held low 10 cycles -> ct_o and ct_valid_o stable, pt_ready_o=0 and key_we_i ignored throughout.
REQ-045 SHALL be verified with: rst_i pulsed at RUN cycle 15 -> all outputs 0, no ct_valid_o, pt_ready_o=0 until a key write.
REQ-046 SHALL be verified with PRESENT_CTRL_BLK_CNT_EN defined and three blocks completed -> blk_cnt_o=3.
